// File: rtl/mtimer_irq.sv
`default_nettype none
// ============================================================================
// Module   : mtimer_irq
// Purpose  : Memory-mapped mtime/mtimecmp timer with a held-until-taken IRQ.
// Revision : 1.0
// ============================================================================
module mtimer_irq #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    input  logic        irq_ack,
    input  logic        is_mret,
    output logic        timer_irq
);

    localparam logic [31:0] C_ADDR_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] C_ADDR_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] C_ADDR_MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] C_ADDR_MT_HI  = 32'h0200_BFFC;
    localparam logic [31:0] C_ADDR_STATUS = 32'h0200_0000;
    localparam logic [15:0] C_PCNT_MAX    = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        timer_irq_q, timer_irq_d;

    logic w_tick;
    logic w_match;
    logic w_wr_mt_lo, w_wr_mt_hi, w_wr_cmp_lo, w_wr_cmp_hi;

    assign w_tick      = (pcnt_q == C_PCNT_MAX);
    assign w_match     = (mtime_q >= mtimecmp_q);
    assign w_wr_mt_lo  = wr_en && (addr == C_ADDR_MT_LO);
    assign w_wr_mt_hi  = wr_en && (addr == C_ADDR_MT_HI);
    assign w_wr_cmp_lo = wr_en && (addr == C_ADDR_CMP_LO);
    assign w_wr_cmp_hi = wr_en && (addr == C_ADDR_CMP_HI);

    // Prescaler and counter; a software write to mtime wins over that cycle's increment.
    always_comb begin
        pcnt_d     = w_tick ? 16'd0 : pcnt_q + 16'd1;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (w_wr_mt_lo) begin
            mtime_d = {mtime_q[63:32], wdata};
        end else if (w_wr_mt_hi) begin
            mtime_d = {wdata, mtime_q[31:0]};
        end else if (w_tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (w_wr_cmp_lo) begin
            mtimecmp_d = {mtimecmp_q[63:32], wdata};
        end else if (w_wr_cmp_hi) begin
            mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        end
    end

    // Transitions look only at pre-write register values via w_match.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_match) state_d = ST_PEND;
            ST_PEND: begin
                if (irq_ack)       state_d = ST_SERV;
                else if (!w_match) state_d = ST_IDLE;
            end
            ST_SERV: if (is_mret) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        timer_irq_d = (state_d == ST_PEND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            pcnt_q      <= 16'd0;
            timer_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            pcnt_q      <= pcnt_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign timer_irq = timer_irq_q;

    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            case (addr)
                C_ADDR_CMP_LO: rdata = mtimecmp_q[31:0];
                C_ADDR_CMP_HI: rdata = mtimecmp_q[63:32];
                C_ADDR_MT_LO:  rdata = mtime_q[31:0];
                C_ADDR_MT_HI:  rdata = mtime_q[63:32];
                C_ADDR_STATUS: rdata = {30'd0, state_q};
                default:       rdata = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mtimer_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtimer_irq
// Purpose  : Directed self-checking bench for mtimer_irq (PRESCALE 1 and 4).
// Revision : 1.0
// ============================================================================
module tb_mtimer_irq;

    localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] A_MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_MT_HI  = 32'h0200_BFFC;
    localparam logic [31:0] A_STATUS = 32'h0200_0000;
    localparam logic [31:0] A_UNMAP  = 32'h0200_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        wr_en = 1'b0, rd_en = 1'b0, irq_ack = 1'b0, is_mret = 1'b0, timer_irq;
    logic [31:0] addr4 = '0, wdata4 = '0, rdata4;
    logic        wr_en4 = 1'b0, rd_en4 = 1'b0, irq4;
    logic        ack4 = 1'b0, mret4 = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    mtimer_irq #(.PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_en(wr_en),
        .rd_en(rd_en), .rdata(rdata), .irq_ack(irq_ack), .is_mret(is_mret),
        .timer_irq(timer_irq)
    );

    mtimer_irq #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .addr(addr4), .wdata(wdata4), .wr_en(wr_en4),
        .rd_en(rd_en4), .rdata(rdata4), .irq_ack(ack4), .is_mret(mret4),
        .timer_irq(irq4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        #1;
        d = rdata;
        rd_en = 1'b0;
    endtask

    task automatic wr4(input logic [31:0] a, input logic [31:0] d);
        addr4 = a; wdata4 = d; wr_en4 = 1'b1;
        tick();
        wr_en4 = 1'b0;
    endtask

    task automatic rd4(input logic [31:0] a, output logic [31:0] d);
        addr4 = a; rd_en4 = 1'b1;
        #1;
        d = rdata4;
        rd_en4 = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        tick(); tick();
        tests_run++;
        if (timer_irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
        rd(A_CMP_HI, v);
        tests_run++;
        if (v !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_cmp_hi: got %h want ffffffff", v); end
        rd(A_MT_LO, v);
        tests_run++;
        if (v !== 32'd0) begin tests_failed++; $display("FAIL reset_mtime: got %h want 0", v); end
        rst = 1'b1;
        repeat (10) tick();
        rd(A_MT_LO, v);
        tests_run++;
        if (v < 32'd9 || v > 32'd11) begin tests_failed++; $display("FAIL idle_mtime_lo: got %0d want 10+-1", v); end
        rd(A_STATUS, v);
        tests_run++;
        if (v !== 32'd0 || timer_irq !== 1'b0) begin
            tests_failed++; $display("FAIL idle_status: got status %h irq %b want 0/0", v, timer_irq);
        end
    endtask

    task automatic test_basic_irq();
        logic [31:0] v;
        bit found = 0;
        wr(A_MT_LO, 32'd0);
        wr(A_CMP_LO, 32'd20);
        wr(A_CMP_HI, 32'd0);
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            rd(A_MT_LO, v);
            if (v == 32'd20) begin
                found = 1;
                tests_run++;
                if (timer_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_early: got %b want 0 at mtime 20", timer_irq); end
                tick();
                tests_run++;
                if (timer_irq !== 1'b1) begin tests_failed++; $display("FAIL irq_latency: got %b want 1 one cycle after mtime 20", timer_irq); end
            end
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL mtime_reach_20: got not-reached want reached within 40 cycles"); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        rd(A_STATUS, v);
        tests_run++;
        if (timer_irq !== 1'b0 || v !== 32'd2) begin
            tests_failed++; $display("FAIL ack_release: got irq %b status %h want 0/2", timer_irq, v);
        end
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        rd(A_STATUS, v);
        tests_run++;
        if (v !== 32'd0 || timer_irq !== 1'b0) begin
            tests_failed++; $display("FAIL mret_idle: got status %h irq %b want 0/0", v, timer_irq);
        end
        tick();
        rd(A_STATUS, v);
        tests_run++;
        if (v !== 32'd1 || timer_irq !== 1'b1) begin
            tests_failed++; $display("FAIL mret_repend: got status %h irq %b want 1/1", v, timer_irq);
        end
    endtask

    task automatic test_cancel();
        logic [31:0] v;
        wr(A_CMP_LO, 32'hFFFF_FFFF);
        tests_run++;
        if (timer_irq !== 1'b1) begin tests_failed++; $display("FAIL cancel_lo_hold: got %b want 1", timer_irq); end
        wr(A_CMP_HI, 32'hFFFF_FFFF);
        rd(A_STATUS, v);
        tests_run++;
        if (timer_irq !== 1'b0 || v !== 32'd0) begin
            tests_failed++; $display("FAIL cancel_drop: got irq %b status %h want 0/0", timer_irq, v);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] lo, hi, st;
        wr(A_MT_HI, 32'hFFFF_FFFF);
        wr(A_MT_LO, 32'hFFFF_FFFE);
        tick(); tick();
        rd(A_MT_LO, lo);
        rd(A_MT_HI, hi);
        tests_run++;
        if (lo !== 32'd0 || hi !== 32'd0) begin
            tests_failed++; $display("FAIL wrap: got %h_%h want 00000000_00000000", hi, lo);
        end
        tick();
        rd(A_STATUS, st);
        tests_run++;
        if (timer_irq !== 1'b0 || st !== 32'd0) begin
            tests_failed++; $display("FAIL wrap_irq: got irq %b status %h want 0/0", timer_irq, st);
        end
        wr(A_MT_HI, 32'd5);
        wr(A_MT_LO, 32'hFFFF_FFFF);
        tick();
        rd(A_MT_LO, lo);
        rd(A_MT_HI, hi);
        tests_run++;
        if (lo !== 32'd0 || hi !== 32'd6) begin
            tests_failed++; $display("FAIL carry: got %h_%h want 00000006_00000000", hi, lo);
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] v0, v1, v;
        bit found = 0;
        rd4(A_MT_LO, v0);
        repeat (12) tick();
        rd4(A_MT_LO, v1);
        tests_run++;
        if (v1 - v0 !== 32'd3) begin tests_failed++; $display("FAIL prescale_rate: got %0d want 3", v1 - v0); end
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            rd4(A_MT_LO, v);
            if (v != v1) found = 1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL prescale_tick: got no increment want one within 8 cycles"); end
        repeat (3) tick();
        wr4(A_MT_LO, 32'h1000);
        rd4(A_MT_LO, v);
        tests_run++;
        if (v !== 32'h1000) begin tests_failed++; $display("FAIL prescale_write: got %h want 00001000", v); end
        repeat (3) tick();
        rd4(A_MT_LO, v);
        tests_run++;
        if (v !== 32'h1000) begin tests_failed++; $display("FAIL prescale_lost: got %h want 00001000", v); end
        tick();
        rd4(A_MT_LO, v);
        tests_run++;
        if (v !== 32'h1001) begin tests_failed++; $display("FAIL prescale_phase: got %h want 00001001", v); end
    endtask

    task automatic test_priority();
        logic [31:0] v, c0, c1, h;
        wr(A_CMP_LO, 32'd0);
        wr(A_CMP_HI, 32'd0);
        tick();
        tests_run++;
        if (timer_irq !== 1'b1) begin tests_failed++; $display("FAIL prio_pend: got %b want 1", timer_irq); end
        irq_ack = 1'b1; is_mret = 1'b1;
        tick();
        irq_ack = 1'b0; is_mret = 1'b0;
        rd(A_STATUS, v);
        tests_run++;
        if (v !== 32'd2 || timer_irq !== 1'b0) begin
            tests_failed++; $display("FAIL prio_ack_mret: got status %h irq %b want 2/0", v, timer_irq);
        end
        repeat (3) tick();
        rd(A_UNMAP, v);
        tests_run++;
        if (v !== 32'd0) begin tests_failed++; $display("FAIL unmapped_read: got %h want 0", v); end
        wr(A_UNMAP, 32'hDEAD_BEEF);
        wr(A_STATUS, 32'd3);
        rd(A_CMP_LO, c0);
        rd(A_CMP_HI, c1);
        rd(A_MT_HI, h);
        rd(A_STATUS, v);
        tests_run++;
        if (c0 !== 32'd0 || c1 !== 32'd0 || h !== 32'd6 || v !== 32'd2) begin
            tests_failed++;
            $display("FAIL unmapped_write: got cmp %h_%h mt_hi %h status %h want 0_0 6 2", c1, c0, h, v);
        end
        addr = A_MT_HI; rd_en = 1'b0;
        #1;
        tests_run++;
        if (rdata !== 32'd0) begin tests_failed++; $display("FAIL rd_en_low: got %h want 0", rdata); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v, c;
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        tick();
        tests_run++;
        if (timer_irq !== 1'b1) begin tests_failed++; $display("FAIL rearm_before_reset: got %b want 1", timer_irq); end
        #2 rst = 1'b0;
        #1;
        rd(A_MT_LO, v);
        rd(A_CMP_LO, c);
        tests_run++;
        if (timer_irq !== 1'b0 || v !== 32'd0 || c !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL async_reset: got irq %b mtime %h cmp %h want 0 0 ffffffff", timer_irq, v, c);
        end
        tick();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_irq();
        test_cancel();
        test_wrap();
        test_prescaler();
        test_priority();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
